// File: rtl/interrupt_ack_sequencer.sv
// 8259A-style acknowledge sequencer: raises INT, runs the 8086 two-pulse INTA
// handshake, maintains the In-Service Register and drives the interrupt vector.
module interrupt_ack_sequencer #(
   parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] irr_req,
   input  logic       inta_n,
   input  logic [4:0] icw2_base,
   input  logic       aeoi,
   input  logic       eoi_strobe,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
   output logic       int_out,
   output logic [7:0] isr,
   output logic [7:0] clr_irr,
   output logic [7:0] data_out,
   output logic       data_oe
);

   typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_t;

   state_t     state;
   logic       inta_q;
   logic       spurious;
   logic [2:0] level;

   logic       fall_c;
   logic       rise_c;
   logic       cand_valid_c;
   logic [2:0] cand_level_c;
   logic [7:0] eoi_mask_c;
   logic [7:0] isr_eoi_c;

   assign fall_c = inta_q & ~inta_n;
   assign rise_c = ~inta_q & inta_n;

   // Fully nested priority: a request must outrank the highest in-service level.
   always_comb begin
      logic blocked;
      blocked      = 1'b0;
      cand_valid_c = 1'b0;
      cand_level_c = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (isr[i]) blocked = 1'b1;
         if (!blocked && !cand_valid_c && irr_req[i]) begin
            cand_valid_c = 1'b1;
            cand_level_c = 3'(i);
         end
      end
   end

   // EOI acts on the registered ISR; a same-cycle set is OR-ed in afterwards.
   always_comb begin
      eoi_mask_c = 8'h00;
      if (eoi_strobe) begin
         if (eoi_specific) eoi_mask_c = 8'h01 << eoi_level;
         else              eoi_mask_c = isr & (~isr + 8'h01);
      end
      isr_eoi_c = isr & ~eoi_mask_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         inta_q   <= 1'b1;
         spurious <= 1'b0;
         level    <= 3'd0;
         int_out  <= 1'b0;
         isr      <= 8'h00;
         clr_irr  <= 8'h00;
         data_out <= 8'h00;
         data_oe  <= 1'b0;
      end else begin
         inta_q  <= inta_n;
         clr_irr <= 8'h00;
         isr     <= isr_eoi_c;
         case (state)
            IDLE: begin
               if (cand_valid_c) begin
                  int_out <= 1'b1;
                  state   <= PEND;
               end
            end
            PEND: begin
               if (fall_c) begin
                  int_out <= 1'b0;
                  state   <= ACK1;
                  if (cand_valid_c) begin
                     level    <= cand_level_c;
                     spurious <= 1'b0;
                     isr      <= isr_eoi_c | (8'h01 << cand_level_c);
                     clr_irr  <= 8'h01 << cand_level_c;
                  end else begin
                     level    <= SPURIOUS_LEVEL;
                     spurious <= 1'b1;
                  end
               end
            end
            ACK1: begin
               if (rise_c) state <= WAIT2;
            end
            WAIT2: begin
               if (fall_c) begin
                  data_oe  <= 1'b1;
                  data_out <= {icw2_base, level};
                  state    <= ACK2;
               end
            end
            ACK2: begin
               if (rise_c) begin
                  data_oe  <= 1'b0;
                  data_out <= 8'h00;
                  if (aeoi && !spurious) isr <= isr_eoi_c & ~(8'h01 << level);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed, table-driven bench for interrupt_ack_sequencer; every row is one
// clock cycle of stimulus followed by the outputs expected after that edge.
module tb_interrupt_ack_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] irr_req;
   logic       inta_n;
   logic [4:0] icw2_base;
   logic       aeoi;
   logic       eoi_strobe;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       int_out;
   logic [7:0] isr;
   logic [7:0] clr_irr;
   logic [7:0] data_out;
   logic       data_oe;

   int checks = 0;
   int errors = 0;

   interrupt_ack_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .irr_req      (irr_req),
      .inta_n       (inta_n),
      .icw2_base    (icw2_base),
      .aeoi         (aeoi),
      .eoi_strobe   (eoi_strobe),
      .eoi_specific (eoi_specific),
      .eoi_level    (eoi_level),
      .int_out      (int_out),
      .isr          (isr),
      .clr_irr      (clr_irr),
      .data_out     (data_out),
      .data_oe      (data_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] irr;
      logic       ia_n;
      logic       ae;
      logic       eoi;
      logic       spec;
      logic [2:0] lvl;
      logic       e_int;
      logic [7:0] e_isr;
      logic [7:0] e_clr;
      logic [7:0] e_data;
      logic       e_oe;
   } vec_t;

   function automatic vec_t v(logic rst, logic [7:0] irr, logic ia_n, logic ae,
                              logic eoi, logic spec, logic [2:0] lvl,
                              logic e_int, logic [7:0] e_isr, logic [7:0] e_clr,
                              logic [7:0] e_data, logic e_oe);
      vec_t r;
      r.rst = rst;   r.irr = irr;     r.ia_n = ia_n;   r.ae = ae;
      r.eoi = eoi;   r.spec = spec;   r.lvl = lvl;
      r.e_int = e_int; r.e_isr = e_isr; r.e_clr = e_clr;
      r.e_data = e_data; r.e_oe = e_oe;
      return r;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one row, clock once, then sample 1ns after the edge.
   task automatic apply(input string tag, input int idx, input vec_t t);
      reset        = t.rst;
      irr_req      = t.irr;
      inta_n       = t.ia_n;
      aeoi         = t.ae;
      eoi_strobe   = t.eoi;
      eoi_specific = t.spec;
      eoi_level    = t.lvl;
      @(posedge clk);
      #1;
      check({tag, ".int_out"},  idx, 8'(int_out),  8'(t.e_int));
      check({tag, ".isr"},      idx, isr,          t.e_isr);
      check({tag, ".clr_irr"},  idx, clr_irr,      t.e_clr);
      check({tag, ".data_out"}, idx, data_out,     t.e_data);
      check({tag, ".data_oe"},  idx, 8'(data_oe),  8'(t.e_oe));
   endtask

   vec_t tbl[33];
   vec_t seq[];

   initial begin
      icw2_base = 5'b01000;
      //          rst irr   ia ae eo sp lvl   int isr    clr    data   oe
      // reset, then basic acknowledge of IR3
      tbl[0]  = v(1, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
      tbl[1]  = v(0, 8'h08, 1, 0, 0, 0, 3'd0, 1, 8'h00, 8'h00, 8'h00, 0);
      tbl[2]  = v(0, 8'h08, 0, 0, 0, 0, 3'd0, 0, 8'h08, 8'h08, 8'h00, 0);
      tbl[3]  = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 8'h00, 0);
      tbl[4]  = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 8'h00, 0);
      tbl[5]  = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 8'h43, 1);
      tbl[6]  = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 8'h43, 1);
      tbl[7]  = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 8'h00, 0);
      // nesting: IR5 blocked by IR3 in service, IR1 accepted
      tbl[8]  = v(0, 8'h20, 1, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 8'h00, 0);
      tbl[9]  = v(0, 8'h02, 1, 0, 0, 0, 3'd0, 1, 8'h08, 8'h00, 8'h00, 0);
      tbl[10] = v(0, 8'h02, 0, 0, 0, 0, 3'd0, 0, 8'h0A, 8'h02, 8'h00, 0);
      tbl[11] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h0A, 8'h00, 8'h00, 0);
      tbl[12] = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h0A, 8'h00, 8'h41, 1);
      tbl[13] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h0A, 8'h00, 8'h00, 0);
      // non-specific then specific EOI
      tbl[14] = v(0, 8'h00, 1, 0, 1, 0, 3'd0, 0, 8'h08, 8'h00, 8'h00, 0);
      tbl[15] = v(0, 8'h00, 1, 0, 1, 1, 3'd3, 0, 8'h00, 8'h00, 8'h00, 0);
      tbl[16] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
      // spurious: request withdrawn before first INTA
      tbl[17] = v(0, 8'h04, 1, 0, 0, 0, 3'd0, 1, 8'h00, 8'h00, 8'h00, 0);
      tbl[18] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 1, 8'h00, 8'h00, 8'h00, 0);
      tbl[19] = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
      tbl[20] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
      tbl[21] = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h47, 1);
      tbl[22] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
      // auto-EOI, acknowledged twice without an EOI command
      tbl[23] = v(0, 8'h01, 1, 1, 0, 0, 3'd0, 1, 8'h00, 8'h00, 8'h00, 0);
      tbl[24] = v(0, 8'h01, 0, 1, 0, 0, 3'd0, 0, 8'h01, 8'h01, 8'h00, 0);
      tbl[25] = v(0, 8'h00, 1, 1, 0, 0, 3'd0, 0, 8'h01, 8'h00, 8'h00, 0);
      tbl[26] = v(0, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h01, 8'h00, 8'h40, 1);
      tbl[27] = v(0, 8'h00, 1, 1, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
      tbl[28] = v(0, 8'h01, 1, 1, 0, 0, 3'd0, 1, 8'h00, 8'h00, 8'h00, 0);
      tbl[29] = v(0, 8'h01, 0, 1, 0, 0, 3'd0, 0, 8'h01, 8'h01, 8'h00, 0);
      tbl[30] = v(0, 8'h00, 1, 1, 0, 0, 3'd0, 0, 8'h01, 8'h00, 8'h00, 0);
      tbl[31] = v(0, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h01, 8'h00, 8'h40, 1);
      tbl[32] = v(0, 8'h00, 1, 1, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);

      for (int i = 0; i < 33; i++) apply("tbl", i, tbl[i]);

      // Specific EOI coinciding with the ISR set of the same level: set wins.
      seq = new[10];
      seq[0] = v(0, 8'h08, 1, 0, 0, 0, 3'd0, 1, 8'h00, 8'h00, 8'h00, 0);
      seq[1] = v(0, 8'h08, 0, 0, 0, 0, 3'd0, 0, 8'h08, 8'h08, 8'h00, 0);
      seq[2] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 8'h00, 0);
      seq[3] = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 8'h43, 1);
      seq[4] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 8'h00, 0);
      seq[5] = v(0, 8'h02, 1, 0, 0, 0, 3'd0, 1, 8'h08, 8'h00, 8'h00, 0);
      seq[6] = v(0, 8'h02, 0, 0, 1, 1, 3'd1, 0, 8'h0A, 8'h02, 8'h00, 0);
      seq[7] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h0A, 8'h00, 8'h00, 0);
      seq[8] = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h0A, 8'h00, 8'h41, 1);
      seq[9] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h0A, 8'h00, 8'h00, 0);
      foreach (seq[i]) apply("eoi_set", i, seq[i]);

      // Non-specific EOI on a different bit than the set: both take effect.
      seq = new[5];
      seq[0] = v(0, 8'h01, 1, 0, 0, 0, 3'd0, 1, 8'h0A, 8'h00, 8'h00, 0);
      seq[1] = v(0, 8'h01, 0, 0, 1, 0, 3'd0, 0, 8'h09, 8'h01, 8'h00, 0);
      seq[2] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h09, 8'h00, 8'h00, 0);
      seq[3] = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h09, 8'h00, 8'h40, 1);
      seq[4] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h09, 8'h00, 8'h00, 0);
      foreach (seq[i]) apply("eoi_diff", i, seq[i]);

      // Reset during WAIT2, then a clean full sequence on IR4.
      seq = new[10];
      seq[0] = v(0, 8'h00, 1, 0, 1, 1, 3'd0, 0, 8'h08, 8'h00, 8'h00, 0);
      seq[1] = v(0, 8'h01, 1, 0, 0, 0, 3'd0, 1, 8'h08, 8'h00, 8'h00, 0);
      seq[2] = v(0, 8'h01, 0, 0, 0, 0, 3'd0, 0, 8'h09, 8'h01, 8'h00, 0);
      seq[3] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h09, 8'h00, 8'h00, 0);
      seq[4] = v(1, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
      seq[5] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
      seq[6] = v(0, 8'h10, 1, 0, 0, 0, 3'd0, 1, 8'h00, 8'h00, 8'h00, 0);
      seq[7] = v(0, 8'h10, 0, 0, 0, 0, 3'd0, 0, 8'h10, 8'h10, 8'h00, 0);
      seq[8] = v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h10, 8'h00, 8'h00, 0);
      seq[9] = v(0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h10, 8'h00, 8'h44, 1);
      foreach (seq[i]) apply("rst_mid", i, seq[i]);
      apply("rst_mid", 10, v(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h10, 8'h00, 8'h00, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
